// File: rtl/matrix_operand_loader.sv
// Streams eight signed elements into 2x2 operands A and B, pulses enable for one
// cycle to sample the downstream determinant, then holds the result until it is
// consumed. Defining MATRIX_LOADER_ABORT_EN adds an abort input.
module matrix_operand_loader #(
    parameter int unsigned WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [4*WIDTH-1:0]   matA,
    output logic [4*WIDTH-1:0]   matB,
    output logic                 enable,
    input  logic [4*WIDTH-1:0]   determinant_in,
    output logic [4*WIDTH-1:0]   out_data,
    output logic                 out_valid,
`ifdef MATRIX_LOADER_ABORT_EN
    input  logic                 abort,
`endif
    input  logic                 out_ready
);

    localparam int unsigned MAT_W = 4 * WIDTH;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_CALC   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_idx;
    logic [WIDTH-1:0]   r_a [4];
    logic [WIDTH-1:0]   r_b [4];
    logic [MAT_W-1:0]   r_out_data;
    logic               r_out_valid;

    logic               w_abort;
    logic               w_in_ready;
    logic               w_enable;
    logic               w_accept;
    logic               w_load_result;
    logic               w_release;

`ifdef MATRIX_LOADER_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode; abort overrides every transition
    always_comb begin
        w_state_nxt   = r_state;
        w_in_ready    = 1'b0;
        w_enable      = 1'b0;
        w_accept      = 1'b0;
        w_load_result = 1'b0;
        w_release     = 1'b0;
        unique case (r_state)
            S_LOAD: begin
                w_in_ready = 1'b1;
                if (in_valid && !w_abort) begin
                    w_accept = 1'b1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_CALC;
                    end
                end
            end
            S_CALC: begin
                w_enable = 1'b1;
                if (!w_abort) begin
                    w_load_result = 1'b1;
                    w_state_nxt   = S_RESULT;
                end
            end
            S_RESULT: begin
                if (out_ready && !w_abort) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
        if (w_abort) begin
            w_state_nxt = S_LOAD;
        end
    end

    // Operand slots, element index and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx       <= 3'd0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
        end else begin
            if (w_abort) begin
                r_idx <= 3'd0;
            end else if (w_accept) begin
                r_idx <= r_idx + 3'd1;
            end

            if (w_accept) begin
                if (r_idx[2]) begin
                    r_b[r_idx[1:0]] <= in_data;
                end else begin
                    r_a[r_idx[1:0]] <= in_data;
                end
            end

            if (w_load_result) begin
                r_out_data  <= determinant_in;
                r_out_valid <= 1'b1;
            end else if (w_release || w_abort) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign enable    = w_enable;
    assign matA      = {r_a[0], r_a[1], r_a[2], r_a[3]};
    assign matB      = {r_b[0], r_b[1], r_b[2], r_b[3]};
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Randomized bench for matrix_operand_loader; emulates the downstream
// multiply-determinant stage and predicts results from the streamed elements.
module tb_matrix_operand_loader;

    localparam int unsigned W  = 7;
    localparam int unsigned MW = 4 * W;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] matA;
    logic [MW-1:0] matB;
    logic          enable;
    logic [MW-1:0] determinant_in;
    logic [MW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
`ifdef MATRIX_LOADER_ABORT_EN
    logic          abort;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    matrix_operand_loader #(.WIDTH(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .matA           (matA),
        .matB           (matB),
        .enable         (enable),
        .determinant_in (determinant_in),
        .out_data       (out_data),
        .out_valid      (out_valid),
`ifdef MATRIX_LOADER_ABORT_EN
        .abort          (abort),
`endif
        .out_ready      (out_ready)
    );

    task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Signed element k (0 = MSB slot) of a packed 2x2 operand
    function automatic longint fld(input logic [MW-1:0] v, input int k);
        logic [MW-1:0]       t;
        logic signed [W-1:0] s;
        t = v >> ((3 - k) * W);
        s = t[W-1:0];
        return longint'(s);
    endfunction

    // det(A*B) truncated to the result width
    function automatic logic [MW-1:0] det_of(input logic [MW-1:0] a, input logic [MW-1:0] b);
        longint c00, c01, c10, c11, d;
        c00 = fld(a, 0) * fld(b, 0) + fld(a, 1) * fld(b, 2);
        c01 = fld(a, 0) * fld(b, 1) + fld(a, 1) * fld(b, 3);
        c10 = fld(a, 2) * fld(b, 0) + fld(a, 3) * fld(b, 2);
        c11 = fld(a, 2) * fld(b, 1) + fld(a, 3) * fld(b, 3);
        d   = c00 * c11 - c01 * c10;
        return MW'(d);
    endfunction

    // Downstream combinational stage
    always_comb determinant_in = det_of(matA, matB);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_elem(input logic [W-1:0] d);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'($urandom);
        tick();
        in_valid  = 1'b0;
    endtask

    // Full transaction; rst_in_result replaces the release handshake with a reset
    task automatic run_stream(input logic [W-1:0] el [8], input int hold,
                              input bit rst_in_result, output logic [MW-1:0] got);
        logic [MW-1:0] ea, eb, ed;
        ea = {el[0], el[1], el[2], el[3]};
        eb = {el[4], el[5], el[6], el[7]};
        ed = det_of(ea, eb);
        got = '0;
        for (int i = 0; i < 8; i++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin
                in_valid  = 1'b0;
                in_data   = W'($urandom);
                out_ready = 1'($urandom);
                tick();
            end
            check("in_ready_load", MW'(in_ready), MW'(1));
            check("enable_load", MW'(enable), MW'(0));
            send_elem(el[i]);
        end
        in_valid  = 1'($urandom);
        in_data   = W'($urandom);
        out_ready = 1'b1;
        check("enable_calc", MW'(enable), MW'(1));
        check("out_valid_calc", MW'(out_valid), MW'(0));
        check("in_ready_calc", MW'(in_ready), MW'(0));
        check("matA", matA, ea);
        check("matB", matB, eb);
        out_ready = 1'b0;
        tick();
        check("enable_result", MW'(enable), MW'(0));
        check("out_valid_result", MW'(out_valid), MW'(1));
        check("out_data", out_data, ed);
        got = out_data;
        repeat (hold) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            tick();
            check("hold_valid", MW'(out_valid), MW'(1));
            check("hold_data", out_data, ed);
            check("hold_in_ready", MW'(in_ready), MW'(0));
        end
        in_valid = 1'b0;
        if (rst_in_result) begin
            out_ready = 1'b1;
            reset     = 1'b1;
            tick();
            reset     = 1'b0;
            out_ready = 1'b0;
            check("rst_result_valid", MW'(out_valid), MW'(0));
            check("rst_result_data", out_data, MW'(0));
            check("rst_result_matA", matA, MW'(0));
            check("rst_result_ready", MW'(in_ready), MW'(1));
        end else begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("release_valid", MW'(out_valid), MW'(0));
            check("release_in_ready", MW'(in_ready), MW'(1));
            check("retain_matA", matA, ea);
            check("retain_matB", matB, eb);
            check("retain_data", out_data, ed);
        end
    endtask

    initial begin
        logic [W-1:0]  el [8];
        logic [MW-1:0] got;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef MATRIX_LOADER_ABORT_EN
        abort     = 1'b0;
`endif
        tick();
        tick();
        reset = 1'b0;
        check("rst_in_ready", MW'(in_ready), MW'(1));
        check("rst_enable", MW'(enable), MW'(0));
        check("rst_out_valid", MW'(out_valid), MW'(0));
        check("rst_out_data", out_data, MW'(0));
        check("rst_matA", matA, MW'(0));
        check("rst_matB", matB, MW'(0));

        el = '{7'd1, 7'd0, 7'd0, 7'd1, 7'd1, 7'd0, 7'd0, 7'd1};
        run_stream(el, 0, 1'b0, got);
        check("identity_det", got, MW'(1));

        el = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd8};
        run_stream(el, 5, 1'b0, got);
        check("seq_det", got, MW'(4));

        el = '{7'h40, 7'd0, 7'd0, 7'h40, 7'd1, 7'd0, 7'd0, 7'd1};
        run_stream(el, 1, 1'b0, got);
        check("neg64_det", got, MW'(4096));

        // Reset after three accepted elements, coincident with a fourth offer
        send_elem(7'd9);
        send_elem(7'd10);
        send_elem(7'd11);
        in_valid = 1'b1;
        in_data  = 7'd12;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        check("midload_rst_matA", matA, MW'(0));
        check("midload_rst_ready", MW'(in_ready), MW'(1));
        el = '{7'd2, 7'd1, 7'd1, 7'd3, 7'h7F, 7'd2, 7'd4, 7'd5};
        run_stream(el, 2, 1'b0, got);

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 8; i++) el[i] = W'($urandom);
            run_stream(el, int'($urandom_range(0, 4)), (t == 7), got);
        end

`ifdef MATRIX_LOADER_ABORT_EN
        begin
            logic [MW-1:0] pa;
            logic [MW-1:0] pb;
            for (int i = 0; i < 8; i++) el[i] = W'($urandom);
            pb = matB;
            for (int i = 0; i < 7; i++) send_elem(el[i]);
            in_valid  = 1'b1;
            in_data   = el[7];
            out_ready = 1'b1;
            abort     = 1'b1;
            tick();
            abort     = 1'b0;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            pa = {el[0], el[1], el[2], el[3]};
            pb = {el[4], el[5], el[6], pb[W-1:0]};
            check("abort_enable", MW'(enable), MW'(0));
            check("abort_in_ready", MW'(in_ready), MW'(1));
            check("abort_out_valid", MW'(out_valid), MW'(0));
            check("abort_matA", matA, pa);
            check("abort_matB", matB, pb);
            tick();
            check("abort_valid_after", MW'(out_valid), MW'(0));
            check("abort_enable_after", MW'(enable), MW'(0));
            for (int i = 0; i < 8; i++) el[i] = W'($urandom);
            run_stream(el, 1, 1'b0, got);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
